// File: rtl/pu_pipe.sv
// pu_pipe: 3-stage signed dot-product unit with weight memory, partial-sum cache,
// bias registers, ReLU and result memory. Define PU_SAT_EN to saturate the adds.
module pu_pipe #(
  parameter int DATA_WIDTH  = 8,
  parameter int NUM_LANES   = 64,
  parameter int ACC_WIDTH   = 22,
  parameter int WADDR_WIDTH = 7,
  parameter int CADDR_WIDTH = 5,
  parameter int RADDR_WIDTH = 7,
  parameter int BADDR_WIDTH = 3
) (
  input  logic                              clk,
  input  logic                              rst_n,
  input  logic                              in_mac_en,
  input  logic [NUM_LANES*DATA_WIDTH-1:0]   in_data,
  input  logic [WADDR_WIDTH-1:0]            in_w_rd_addr,
  input  logic                              in_first,
  input  logic                              in_last,
  input  logic [CADDR_WIDTH-1:0]            in_cache_addr,
  input  logic                              in_cache_clear,
  input  logic                              in_add_bias,
  input  logic                              in_relu,
  input  logic [BADDR_WIDTH-1:0]            in_bias_addr,
  input  logic [RADDR_WIDTH-1:0]            in_r_wr_addr,
  input  logic                              in_w_wr_en,
  input  logic [WADDR_WIDTH-1:0]            in_w_wr_addr,
  input  logic [NUM_LANES*DATA_WIDTH-1:0]   in_w_wr_data,
  input  logic                              in_b_wr_en,
  input  logic [BADDR_WIDTH-1:0]            in_b_wr_addr,
  input  logic [ACC_WIDTH-1:0]              in_b_wr_data,
  input  logic                              in_r_rd_en,
  input  logic [RADDR_WIDTH-1:0]            in_r_rd_addr,
  output logic                              out_valid,
  output logic [ACC_WIDTH-1:0]              out_sum,
  output logic                              out_last,
  output logic [ACC_WIDTH-1:0]              out_rmem,
  output logic                              out_rmem_valid,
  output logic                              out_busy
);

  localparam int ROW_W  = NUM_LANES * DATA_WIDTH;
  localparam int PROD_W = 2 * DATA_WIDTH;

  typedef struct packed {
    logic                   first;
    logic                   last;
    logic [CADDR_WIDTH-1:0] cache_addr;
    logic                   add_bias;
    logic                   relu;
    logic [BADDR_WIDTH-1:0] bias_addr;
    logic [RADDR_WIDTH-1:0] r_wr_addr;
  } ctl_t;

  logic [ROW_W-1:0]            w_mem [2**WADDR_WIDTH];
  logic [ACC_WIDTH-1:0]        r_mem [2**RADDR_WIDTH];
  logic signed [ACC_WIDTH-1:0] cache [2**CADDR_WIDTH];
  logic signed [ACC_WIDTH-1:0] bias  [2**BADDR_WIDTH];

  logic                        s1_valid;
  ctl_t                        s1_ctl;
  logic [ROW_W-1:0]            s1_w;
  logic [ROW_W-1:0]            s1_data;

  logic                        s2_valid;
  ctl_t                        s2_ctl;
  logic signed [ACC_WIDTH-1:0] s2_sum;

  logic signed [ACC_WIDTH-1:0] tree_sum;
  logic signed [ACC_WIDTH-1:0] slot_val;
  logic signed [ACC_WIDTH-1:0] bias_val;
  logic signed [ACC_WIDTH-1:0] acc;
  logic signed [ACC_WIDTH-1:0] biased;
  logic signed [ACC_WIDTH-1:0] fin;
  logic signed [ACC_WIDTH-1:0] s3_val;

  function automatic logic signed [ACC_WIDTH-1:0] lane_prod(
    input logic signed [DATA_WIDTH-1:0] a,
    input logic signed [DATA_WIDTH-1:0] b
  );
    logic signed [PROD_W-1:0] p;
    p = PROD_W'(a) * PROD_W'(b);
    return ACC_WIDTH'(p);
  endfunction

  function automatic logic signed [ACC_WIDTH-1:0] add_acc(
    input logic signed [ACC_WIDTH-1:0] a,
    input logic signed [ACC_WIDTH-1:0] b
  );
`ifdef PU_SAT_EN
    logic signed [ACC_WIDTH:0] full;
    full = {a[ACC_WIDTH-1], a} + {b[ACC_WIDTH-1], b};
    // Extra sign bit disagreeing with the top result bit means overflow.
    if (full[ACC_WIDTH] != full[ACC_WIDTH-1]) begin
      if (full[ACC_WIDTH]) return {1'b1, {(ACC_WIDTH-1){1'b0}}};
      else                 return {1'b0, {(ACC_WIDTH-1){1'b1}}};
    end
    return full[ACC_WIDTH-1:0];
`else
    return a + b;
`endif
  endfunction

  always_ff @(posedge clk) begin
    if (in_w_wr_en) w_mem[in_w_wr_addr] <= in_w_wr_data;
  end

  // S1: registered weight row read (old row on a same-cycle write) and activations.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      s1_valid <= 1'b0;
      s1_ctl   <= '0;
      s1_w     <= '0;
      s1_data  <= '0;
    end else begin
      s1_valid <= in_mac_en;
      if (in_mac_en) begin
        s1_ctl  <= '{first: in_first, last: in_last, cache_addr: in_cache_addr,
                     add_bias: in_add_bias, relu: in_relu, bias_addr: in_bias_addr,
                     r_wr_addr: in_r_wr_addr};
        s1_w    <= w_mem[in_w_rd_addr];
        s1_data <= in_data;
      end
    end
  end

  // Written as a chain; synthesis rebalances it into an adder tree.
  always_comb begin
    tree_sum = '0;
    for (int i = 0; i < NUM_LANES; i++) begin
      tree_sum = tree_sum + lane_prod(s1_data[i*DATA_WIDTH +: DATA_WIDTH],
                                      s1_w[i*DATA_WIDTH +: DATA_WIDTH]);
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      s2_valid <= 1'b0;
      s2_ctl   <= '0;
      s2_sum   <= '0;
    end else begin
      s2_valid <= s1_valid;
      if (s1_valid) begin
        s2_ctl <= s1_ctl;
        s2_sum <= tree_sum;
      end
    end
  end

  // S3 read-modify-write of the cache slot happens in one cycle, so back-to-back
  // issues to the same slot see each other's result without forwarding.
  assign slot_val = s2_ctl.first ? '0 : cache[s2_ctl.cache_addr];
  assign acc      = add_acc(slot_val, s2_sum);
  assign bias_val = s2_ctl.add_bias ? bias[s2_ctl.bias_addr] : '0;
  assign biased   = add_acc(acc, bias_val);
  assign fin      = (s2_ctl.relu && biased[ACC_WIDTH-1]) ? '0 : biased;
  assign s3_val   = s2_ctl.last ? fin : acc;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      out_valid <= 1'b0;
      out_last  <= 1'b0;
      out_sum   <= '0;
    end else begin
      out_valid <= s2_valid;
      out_last  <= s2_valid & s2_ctl.last;
      if (s2_valid) out_sum <= s3_val;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      for (int i = 0; i < 2**CADDR_WIDTH; i++) cache[i] <= '0;
    end else if (in_cache_clear) begin
      for (int i = 0; i < 2**CADDR_WIDTH; i++) cache[i] <= '0;
    end else if (s2_valid) begin
      cache[s2_ctl.cache_addr] <= s2_ctl.last ? '0 : acc;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      for (int i = 0; i < 2**BADDR_WIDTH; i++) bias[i] <= '0;
    end else if (in_b_wr_en) begin
      bias[in_b_wr_addr] <= in_b_wr_data;
    end
  end

  // Gated with rst_n so an issue caught by reset never lands in the result memory.
  always_ff @(posedge clk) begin
    if (rst_n && s2_valid && s2_ctl.last) r_mem[s2_ctl.r_wr_addr] <= fin;
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      out_rmem       <= '0;
      out_rmem_valid <= 1'b0;
    end else begin
      out_rmem_valid <= in_r_rd_en;
      if (in_r_rd_en) out_rmem <= r_mem[in_r_rd_addr];
    end
  end

  assign out_busy = s1_valid | s2_valid | out_valid;

endmodule

// File: tb/tb_pu_pipe.sv
// Self-checking bench for pu_pipe: vector table, hand-written corner sequences and
// randomized issues checked against an arithmetic model of the dot-product unit.
module tb_pu_pipe;
  localparam int DW = 8, NL = 64, AW = 22, WA = 7, CA = 5, RA = 7, BA = 3;
  localparam int ROW_W = DW * NL;

`ifdef PU_SAT_EN
  localparam longint ACC_MAX = 2097151;
  localparam longint ACC_MIN = -2097152;
  localparam longint SAT2    = 2097151;
`else
  localparam longint SAT2    = -2097152;
`endif

  logic              clk = 1'b0;
  logic              rst_n = 1'b0;
  logic              in_mac_en, in_first, in_last, in_cache_clear, in_add_bias, in_relu;
  logic [ROW_W-1:0]  in_data, in_w_wr_data;
  logic [WA-1:0]     in_w_rd_addr, in_w_wr_addr;
  logic [CA-1:0]     in_cache_addr;
  logic [BA-1:0]     in_bias_addr, in_b_wr_addr;
  logic [RA-1:0]     in_r_wr_addr, in_r_rd_addr;
  logic              in_w_wr_en, in_b_wr_en, in_r_rd_en;
  logic [AW-1:0]     in_b_wr_data;
  logic              out_valid, out_last, out_rmem_valid, out_busy;
  logic [AW-1:0]     out_sum, out_rmem;

  pu_pipe dut (
    .clk(clk), .rst_n(rst_n), .in_mac_en(in_mac_en), .in_data(in_data),
    .in_w_rd_addr(in_w_rd_addr), .in_first(in_first), .in_last(in_last),
    .in_cache_addr(in_cache_addr), .in_cache_clear(in_cache_clear),
    .in_add_bias(in_add_bias), .in_relu(in_relu), .in_bias_addr(in_bias_addr),
    .in_r_wr_addr(in_r_wr_addr), .in_w_wr_en(in_w_wr_en), .in_w_wr_addr(in_w_wr_addr),
    .in_w_wr_data(in_w_wr_data), .in_b_wr_en(in_b_wr_en), .in_b_wr_addr(in_b_wr_addr),
    .in_b_wr_data(in_b_wr_data), .in_r_rd_en(in_r_rd_en), .in_r_rd_addr(in_r_rd_addr),
    .out_valid(out_valid), .out_sum(out_sum), .out_last(out_last), .out_rmem(out_rmem),
    .out_rmem_valid(out_rmem_valid), .out_busy(out_busy)
  );

  // ---------------- clock / reset ----------------
  always #5 clk = ~clk;

  int cyc = 0;
  always @(posedge clk) cyc <= cyc + 1;

  initial begin
    #2000000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1);
  end

  // ---------------- scoreboard ----------------
  int checks = 0;
  int errors = 0;
  logic [AW:0] exp_q[$];
  int          exp_cyc_q[$];
  logic [AW:0] mon_e;
  int          mon_c;

  task automatic check(input string name, input longint got, input longint want);
    checks++;
    if (got != want) begin
      errors++;
      $display("FAIL %s: got %0d, want %0d", name, got, want);
    end
  endtask

  always @(negedge clk) begin
    if (rst_n && out_valid) begin
      if (exp_q.size() == 0) begin
        checks++;
        errors++;
        $display("FAIL unexpected_valid: got out_valid=1 sum=%0d at cycle %0d, want no output",
                 $signed(out_sum), cyc);
      end else begin
        mon_e = exp_q.pop_front();
        mon_c = exp_cyc_q.pop_front();
        checks++;
        if ({out_last, out_sum} !== mon_e) begin
          errors++;
          $display("FAIL out_sum: got sum=%0d last=%0b, want sum=%0d last=%0b",
                   $signed(out_sum), out_last, $signed(mon_e[AW-1:0]), mon_e[AW]);
        end
        checks++;
        if (cyc != mon_c) begin
          errors++;
          $display("FAIL latency: got valid at cycle %0d, want cycle %0d", cyc, mon_c);
        end
      end
    end
  end

  // ---------------- reference model ----------------
  logic signed [DW-1:0] m_w [128][NL];
  longint m_cache [32];
  longint m_bias [8];
  longint m_rmem [128];
  int     written_q[$];

  function automatic longint fit(input longint x);
    logic signed [AW-1:0] t;
`ifdef PU_SAT_EN
    if (x > ACC_MAX) return ACC_MAX;
    if (x < ACC_MIN) return ACC_MIN;
`endif
    t = x[AW-1:0];
    return longint'(t);
  endfunction

  function automatic longint dot(input int row, input logic [ROW_W-1:0] d);
    longint s = 0;
    for (int i = 0; i < NL; i++)
      s += longint'(m_w[row][i]) * longint'($signed(d[i*DW +: DW]));
    return s;
  endfunction

  function automatic logic [ROW_W-1:0] fill(input logic [7:0] b);
    return {NL{b}};
  endfunction

  // ---------------- driver tasks ----------------
  task automatic idle(input int n);
    repeat (n) @(negedge clk);
  endtask

  task automatic write_w(input int row, input logic [ROW_W-1:0] r);
    in_w_wr_en = 1'b1; in_w_wr_addr = WA'(row); in_w_wr_data = r;
    for (int i = 0; i < NL; i++) m_w[row][i] = r[i*DW +: DW];
    @(negedge clk);
    in_w_wr_en = 1'b0;
  endtask

  task automatic write_b(input int addr, input longint v);
    in_b_wr_en = 1'b1; in_b_wr_addr = BA'(addr); in_b_wr_data = AW'(v);
    m_bias[addr] = v;
    @(negedge clk);
    in_b_wr_en = 1'b0;
  endtask

  task automatic issue(input int row, input logic [ROW_W-1:0] d, input logic first,
                       input logic last, input int slot, input logic ab, input logic rl,
                       input int baddr, input int raddr, input logic use_given,
                       input longint given);
    longint slotv, acc, v, want;
    slotv = first ? 0 : m_cache[slot];
    acc = fit(slotv + fit(dot(row, d)));
    if (last) begin
      v = ab ? fit(acc + m_bias[baddr]) : acc;
      if (rl && v < 0) v = 0;
      m_cache[slot] = 0;
      m_rmem[raddr] = v;
      want = v;
    end else begin
      m_cache[slot] = acc;
      want = acc;
    end
    if (use_given) want = given;
    exp_q.push_back({last, AW'(want)});
    exp_cyc_q.push_back(cyc + 3);
    in_mac_en = 1'b1; in_data = d; in_w_rd_addr = WA'(row); in_first = first;
    in_last = last; in_cache_addr = CA'(slot); in_add_bias = ab; in_relu = rl;
    in_bias_addr = BA'(baddr); in_r_wr_addr = RA'(raddr);
    @(negedge clk);
    in_mac_en = 1'b0;
  endtask

  task automatic read_r(input int addr, input longint want);
    in_r_rd_en = 1'b1; in_r_rd_addr = RA'(addr);
    @(negedge clk);
    in_r_rd_en = 1'b0;
    check("rmem_valid", longint'(out_rmem_valid), 1);
    check("rmem_data", longint'($signed(out_rmem)), want);
    @(negedge clk);
    check("rmem_valid_drop", longint'(out_rmem_valid), 0);
  endtask

  // ---------------- vector table ----------------
  typedef struct {
    logic [7:0] w;
    logic [7:0] d;
    logic       ab;
    logic       rl;
    int         ba;
    longint     want;
  } vec_t;
  vec_t tab[12];

  // ---------------- test sequence ----------------
  initial begin
    logic [ROW_W-1:0] rd;
    longint old9;
    int ra;

    tab[0]  = '{8'h01, 8'h02, 1'b0, 1'b0, 0, 128};
    tab[1]  = '{8'hFF, 8'h02, 1'b1, 1'b0, 3, -28};
    tab[2]  = '{8'hFF, 8'h02, 1'b0, 1'b1, 0, 0};
    tab[3]  = '{8'hFF, 8'h02, 1'b1, 1'b1, 0, 0};
    tab[4]  = '{8'h03, 8'hFD, 1'b0, 1'b0, 0, -576};
    tab[5]  = '{8'h7F, 8'h7F, 1'b0, 1'b0, 0, 1032256};
    tab[6]  = '{8'h80, 8'h80, 1'b0, 1'b0, 0, 1048576};
    tab[7]  = '{8'h80, 8'h7F, 1'b0, 1'b0, 0, -1040384};
    tab[8]  = '{8'h05, 8'h04, 1'b1, 1'b1, 5, 280};
    tab[9]  = '{8'h01, 8'h01, 1'b1, 1'b1, 5, 0};
    tab[10] = '{8'h10, 8'hF0, 1'b0, 1'b1, 0, 0};
    tab[11] = '{8'h00, 8'h55, 1'b1, 1'b0, 5, -1000};

    in_mac_en = 0; in_first = 0; in_last = 0; in_cache_clear = 0; in_add_bias = 0;
    in_relu = 0; in_data = '0; in_w_wr_data = '0; in_w_rd_addr = '0; in_w_wr_addr = '0;
    in_cache_addr = '0; in_bias_addr = '0; in_b_wr_addr = '0; in_r_wr_addr = '0;
    in_r_rd_addr = '0; in_w_wr_en = 0; in_b_wr_en = 0; in_r_rd_en = 0; in_b_wr_data = '0;
    for (int i = 0; i < 32; i++) m_cache[i] = 0;
    for (int i = 0; i < 8; i++) m_bias[i] = 0;
    for (int i = 0; i < 128; i++) m_rmem[i] = 0;

    rst_n = 1'b0;
    idle(3);
    check("rst_out_valid", longint'(out_valid), 0);
    check("rst_out_sum", longint'(out_sum), 0);
    check("rst_out_last", longint'(out_last), 0);
    check("rst_out_rmem", longint'(out_rmem), 0);
    check("rst_out_rmem_valid", longint'(out_rmem_valid), 0);
    check("rst_out_busy", longint'(out_busy), 0);
    rst_n = 1'b1;
    idle(1);

    // Table: one-shot first+last issues, back to back.
    write_b(3, 100);
    write_b(5, -1000);
    for (int k = 0; k < 12; k++) write_w(k, fill(tab[k].w));
    for (int k = 0; k < 12; k++)
      issue(k, fill(tab[k].d), 1, 1, 10 + k, tab[k].ab, tab[k].rl, tab[k].ba, 100 + k,
            1, tab[k].want);
    check("busy_in_flight", longint'(out_busy), 1);
    idle(5);
    check("busy_drained", longint'(out_busy), 0);

    // Accumulation over three back-to-back issues to slot 5.
    issue(0, fill(8'h02), 1, 0, 5, 0, 0, 0, 20, 1, 128);
    issue(0, fill(8'h02), 0, 0, 5, 0, 0, 0, 20, 1, 256);
    issue(0, fill(8'h02), 0, 1, 5, 0, 0, 0, 20, 1, 384);
    idle(4);

    // Result memory write then read.
    issue(0, fill(8'h02), 1, 1, 6, 0, 0, 0, 9, 1, 128);
    idle(4);
    read_r(9, 128);

    // Two-issue sum of 2^21: saturates or wraps.
    issue(6, fill(8'h80), 1, 0, 2, 0, 0, 0, 21, 1, 1048576);
    issue(6, fill(8'h80), 0, 1, 2, 0, 0, 0, 21, 1, SAT2);
    idle(4);

    // Weight write and read of the same row in one cycle returns the old row.
    write_w(40, fill(8'h01));
    in_w_wr_en = 1'b1; in_w_wr_addr = WA'(40); in_w_wr_data = fill(8'h02);
    issue(40, fill(8'h02), 1, 1, 7, 0, 0, 0, 22, 1, 128);
    in_w_wr_en = 1'b0;
    for (int i = 0; i < NL; i++) m_w[40][i] = 8'h02;
    issue(40, fill(8'h02), 1, 1, 7, 0, 0, 0, 22, 1, 256);
    idle(4);

    // Cache clear coincident with the S3 write to slot 5.
    issue(0, fill(8'h02), 1, 0, 5, 0, 0, 0, 23, 1, 128);
    @(negedge clk);
    in_cache_clear = 1'b1;
    @(negedge clk);
    in_cache_clear = 1'b0;
    for (int i = 0; i < 32; i++) m_cache[i] = 0;
    issue(0, fill(8'h02), 0, 1, 5, 0, 0, 0, 23, 1, 128);
    idle(4);

    // Randomized issues against the model.
    for (int r = 16; r < 32; r++) begin
      for (int i = 0; i < NL; i++) rd[i*DW +: DW] = 8'($urandom_range(0, 255));
      write_w(r, rd);
    end
    for (int b = 0; b < 8; b++) write_b(b, longint'($urandom_range(0, 10000)) - 5000);
    for (int n = 0; n < 80; n++) begin
      for (int i = 0; i < NL; i++) rd[i*DW +: DW] = 8'($urandom_range(0, 255));
      ra = 32 + $urandom_range(0, 31);
      issue(16 + $urandom_range(0, 15), rd, $urandom_range(0, 3) == 0,
            $urandom_range(0, 2) == 0, $urandom_range(0, 7), 1'($urandom_range(0, 1)),
            1'($urandom_range(0, 1)), $urandom_range(0, 7), ra, 0, 0);
      if (in_last) written_q.push_back(ra);
      if ($urandom_range(0, 4) == 0) idle($urandom_range(1, 3));
    end
    idle(6);
    for (int k = 0; k < 8 && k < written_q.size(); k++)
      read_r(written_q[k], m_rmem[written_q[k]]);

    // Reset with two issues in flight: neither completes nor writes memory.
    old9 = m_rmem[9];
    issue(6, fill(8'h80), 1, 1, 9, 0, 0, 0, 9, 0, 0);
    issue(0, fill(8'h02), 1, 0, 3, 0, 0, 0, 9, 0, 0);
    rst_n = 1'b0;
    exp_q.delete();
    exp_cyc_q.delete();
    for (int i = 0; i < 32; i++) m_cache[i] = 0;
    for (int i = 0; i < 8; i++) m_bias[i] = 0;
    m_rmem[9] = old9;
    #1;
    check("rst_mid_busy", longint'(out_busy), 0);
    check("rst_mid_valid", longint'(out_valid), 0);
    idle(2);
    rst_n = 1'b1;
    idle(5);
    check("rst_mid_busy_after", longint'(out_busy), 0);
    read_r(9, old9);
    issue(0, fill(8'h02), 1, 1, 3, 1, 0, 3, 24, 0, 0);
    idle(5);

    check("drain", longint'(exp_q.size()), 0);
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
